// File: rtl/bcd_up_down_counter.sv
// Four-digit BCD up/down counter with synchronised, edge-detected push-button inputs.
// Drives the per-digit nibbles consumed by the seven-segment controller's digit mux.
module bcd_up_down_counter #(
    parameter logic [15:0] InitValue  = 16'h0000,
    parameter int          SyncStages = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Up,
    input  logic        Down,
    input  logic        Load,
    input  logic [15:0] LoadValue,
    output logic [15:0] Digits,
    output logic        Overflow,
    output logic        Underflow
);

    // Any nibble above 9 is forced to 9 so the count never holds a non-BCD digit.
    function automatic logic [15:0] clamp_bcd(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Result is {carry_out, value}; carry_out is set only on the 9999 -> 0000 wrap.
    function automatic logic [16:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    c           = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Result is {borrow_out, value}; borrow_out is set only on the 0000 -> 9999 wrap.
    function automatic logic [16:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (b) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    b           = 1'b0;
                end
            end
        end
        return {b, r};
    endfunction

    localparam logic [15:0] init_digits = clamp_bcd(InitValue);

    logic [SyncStages-1:0] up_sync_q,   up_sync_d;
    logic [SyncStages-1:0] down_sync_q, down_sync_d;
    logic                  up_prev_q,   up_prev_d;
    logic                  down_prev_q, down_prev_d;
    logic [15:0]           digits_q,    digits_d;
    logic                  overflow_q,  overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  up_evt;
    logic                  down_evt;

    always_comb begin
        up_sync_d   = {up_sync_q[SyncStages-2:0], Up};
        down_sync_d = {down_sync_q[SyncStages-2:0], Down};
        up_prev_d   = up_sync_q[SyncStages-1];
        down_prev_d = down_sync_q[SyncStages-1];
        up_evt      = up_sync_q[SyncStages-1] & ~up_prev_q;
        down_evt    = down_sync_q[SyncStages-1] & ~down_prev_q;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        digits_d    = digits_q;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        if (Load) begin
            digits_d = clamp_bcd(LoadValue);
        end else if (up_evt && !down_evt) begin
            {overflow_d, digits_d} = bcd_inc(digits_q);
        end else if (down_evt && !up_evt) begin
            {underflow_d, digits_d} = bcd_dec(digits_q);
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            up_sync_q   <= '0;
            down_sync_q <= '0;
            up_prev_q   <= 1'b0;
            down_prev_q <= 1'b0;
            digits_q    <= init_digits;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            up_sync_q   <= up_sync_d;
            down_sync_q <= down_sync_d;
            up_prev_q   <= up_prev_d;
            down_prev_q <= down_prev_d;
            digits_q    <= digits_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign Digits    = digits_q;
    assign Overflow  = overflow_q;
    assign Underflow = underflow_q;

endmodule

// File: tb/tb_bcd_up_down_counter.sv
// Scoreboard bench for bcd_up_down_counter: expected {Digits, Overflow, Underflow}
// is queued when stimulus is driven and popped when the DUT output is sampled.
module tb_bcd_up_down_counter;

    logic        Clk;
    logic        Reset;
    logic        Up;
    logic        Down;
    logic        Load;
    logic [15:0] LoadValue;
    logic [15:0] Digits;
    logic        Overflow;
    logic        Underflow;

    logic [17:0] sb[$];
    logic [17:0] exp_v;
    int          tests_run;
    int          tests_failed;

    bcd_up_down_counter #(
        .InitValue (16'h0000),
        .SyncStages(2)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Up       (Up),
        .Down     (Down),
        .Load     (Load),
        .LoadValue(LoadValue),
        .Digits   (Digits),
        .Overflow (Overflow),
        .Underflow(Underflow)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        Load      = 1'b1;
        LoadValue = v;
        tick(1);
        Load      = 1'b0;
    endtask

    // Raises the selected buttons; after three edges the event has been applied.
    task automatic raise(input logic u, input logic d);
        Up   = u;
        Down = d;
        tick(3);
    endtask

    task automatic release_buttons();
        Up   = 1'b0;
        Down = 1'b0;
        tick(3);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Up = 1'b0; Down = 1'b0; Load = 1'b0; LoadValue = 16'h0000;
        #2;
        sb.push_back({16'h0000, 2'b00});
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_async: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(3);
        Reset = 1'b0;
        tick(1);
        sb.push_back({16'h0000, 2'b00});
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_release: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic test_hold_up();
        Up = 1'b1;
        sb.push_back({16'h0000, 2'b00});
        sb.push_back({16'h0001, 2'b00});
        sb.push_back({16'h0001, 2'b00});
        tick(2);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL hold_edge2: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(1);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL hold_edge3: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(7);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL hold_no_repeat: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        release_buttons();
    endtask

    task automatic test_carry_chain();
        logic [15:0] start_v [3];
        logic [15:0] up_v    [3];
        start_v = '{16'h0999, 16'h0009, 16'h1299};
        up_v    = '{16'h1000, 16'h0010, 16'h1300};
        for (int i = 0; i < 3; i++) begin
            do_load(start_v[i]);
            sb.push_back({up_v[i], 2'b00});
            raise(1'b1, 1'b0);
            exp_v = sb.pop_front();
            tests_run++;
            if ({Digits, Overflow, Underflow} !== exp_v) begin
                tests_failed++;
                $display("FAIL carry_up[%0d]: got %h/%b/%b want %h/%b/%b", i, Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
            end
            release_buttons();
            sb.push_back({start_v[i], 2'b00});
            raise(1'b0, 1'b1);
            exp_v = sb.pop_front();
            tests_run++;
            if ({Digits, Overflow, Underflow} !== exp_v) begin
                tests_failed++;
                $display("FAIL borrow_down[%0d]: got %h/%b/%b want %h/%b/%b", i, Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
            end
            release_buttons();
        end
    endtask

    task automatic test_wrap();
        do_load(16'h9999);
        sb.push_back({16'h0000, 2'b10});
        sb.push_back({16'h0000, 2'b00});
        raise(1'b1, 1'b0);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL overflow_pulse: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(1);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL overflow_clear: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        release_buttons();
        sb.push_back({16'h9999, 2'b01});
        sb.push_back({16'h9999, 2'b00});
        raise(1'b0, 1'b1);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL underflow_pulse: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(1);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL underflow_clear: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        release_buttons();
    endtask

    task automatic test_cancel();
        do_load(16'h0042);
        sb.push_back({16'h0042, 2'b00});
        sb.push_back({16'h0042, 2'b00});
        raise(1'b1, 1'b1);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL cancel_edge: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(2);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL cancel_after: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        release_buttons();
    endtask

    task automatic test_load_beats_event();
        Up = 1'b1;
        tick(2);
        sb.push_back({16'h1234, 2'b00});
        sb.push_back({16'h1234, 2'b00});
        do_load(16'h1234);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL load_vs_event: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(3);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL event_dropped: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        release_buttons();
    endtask

    task automatic test_clamp();
        sb.push_back({16'h9959, 2'b00});
        do_load(16'hFA5C);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL load_clamp: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic test_reset_mid();
        Up = 1'b1;
        tick(1);
        Reset = 1'b1;
        #2;
        sb.push_back({16'h0000, 2'b00});
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL reset_mid_async: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        Up = 1'b0;
        tick(2);
        Reset = 1'b0;
        tick(5);
        sb.push_back({16'h0000, 2'b00});
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL pending_lost: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        Reset = 1'b1;
        Up    = 1'b1;
        tick(2);
        Reset = 1'b0;
        sb.push_back({16'h0000, 2'b00});
        sb.push_back({16'h0001, 2'b00});
        sb.push_back({16'h0001, 2'b00});
        tick(2);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL held_rel_edge2: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(1);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL held_rel_edge3: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        tick(6);
        exp_v = sb.pop_front();
        tests_run++;
        if ({Digits, Overflow, Underflow} !== exp_v) begin
            tests_failed++;
            $display("FAIL held_rel_once: got %h/%b/%b want %h/%b/%b", Digits, Overflow, Underflow, exp_v[17:2], exp_v[1], exp_v[0]);
        end
        release_buttons();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_hold_up();
        test_carry_chain();
        test_wrap();
        test_cancel();
        test_load_beats_event();
        test_clamp();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bcd_up_down_counter.md
# bcd_up_down_counter

Four-digit BCD up/down counter that produces the digit values multiplexed onto the Basys3 seven-segment display. It sits directly upstream of the seven-segment controller/digit mux: its `Digits` bus feeds the per-digit data that the controller's `Selector` picks one nibble at a time. Push-button inputs are synchronised and edge-detected internally, so one press gives exactly one count step.

## Interface
- `InitValue`, 16'h0000: BCD value loaded on reset; nibble 3 = thousands, nibble 0 = units.
- `SyncStages`, 2: depth of each input synchroniser chain; legal range 2–4.
- `Clk`  input  1: system clock; all state updates on the rising edge.
- `Reset`  input  1: one clock; reset is asynchronous and active-high.
- `Up`  input  1: debounced button level, asynchronous to `Clk`; each rising edge requests +1.
- `Down`  input  1: debounced button level, asynchronous to `Clk`; each rising edge requests −1.
- `Load`  input  1: synchronous to `Clk`; when high, loads `LoadValue` at the next edge.
- `LoadValue`  input  16: BCD value to load, four nibbles.
- `Digits`  output  16: current count in BCD; `[3:0]` units … `[15:12]` thousands.
- `Overflow`  output  1: one-cycle pulse when the count wraps 9999 → 0000.
- `Underflow`  output  1: one-cycle pulse when the count wraps 0000 → 9999.

## Operation
- Synchroniser: per input, `SyncStages` flops in series, then one "previous" flop. Event = last sync stage high AND previous flop low. Both inputs use separate, identical chains.
- Priority at each rising edge:
  - `Load` beats any event.
  - Otherwise a lone up event or a lone down event applies.
  - Simultaneous up and down events cancel: no change and no pulse.
- Load:
  - `Digits` ← `LoadValue`, with each nibble > 9 clamped to 9.
  - No `Overflow`/`Underflow` pulse.
  - Any event in the same cycle is discarded, not deferred.
- Increment is a ripple BCD add:
  - Units +1; a digit at 9 becomes 0 and carries into the next digit.
  - 9999 + 1 = 0000 with `Overflow` = 1 for that one cycle.
- Decrement is a ripple BCD subtract:
  - A digit at 0 becomes 9 and borrows from the next digit.
  - 0000 − 1 = 9999 with `Underflow` = 1 for that one cycle.
- Held button: exactly one event per rising edge of the input; no auto-repeat.
- Digit values always stay in 0–9. `InitValue` nibbles > 9 are clamped to 9, as for load.

## Timing
- Reset values, all asynchronous:
  - `Digits` = clamped `InitValue`.
  - `Overflow` = 0, `Underflow` = 0.
  - All synchroniser and previous flops = 0.
- Button latency: `Up`/`Down` rising before edge 1 → `Digits` updates at edge `SyncStages`+1. For the default, that is the 3rd rising edge.
- Button pulses shorter than one `Clk` period may be missed. The minimum guaranteed input high and low time is 2 clock periods.
- `Load` latency: sampled at an edge and visible right after that same edge (1 edge).
- `Overflow`/`Underflow` are registered: they are asserted in the same cycle that `Digits` shows the wrapped value and are cleared at the next edge unless another wrap occurs.
- Reset mid-operation:
  - In-flight synchroniser state is lost, so a pending press produces no event.
  - If a button is still held high through reset release, the previous flop is 0, so exactly one event occurs `SyncStages`+1 edges after release.
- Throughput: at most one count step per clock.

## Test plan
- Reset with `InitValue`=16'h0000, `SyncStages`=2 → `Digits`=0000, `Overflow`=`Underflow`=0. Hold `Up` high for 10 cycles → `Digits`=0001 at the 3rd edge and stays 0001 while held.
- Load 16'h0999, then one `Up` press → 1000 (carry chain through three digits). Then one `Down` press → 0999.
- Load 16'h9999, then `Up` → 0000 with `Overflow`=1 for exactly one cycle. Then `Down` → 9999 with `Underflow`=1 for exactly one cycle.
- Raise `Up` and `Down` in the same cycle at count 0042 → no change and no pulses. Next, raise `Load` with 16'h1234 in the same cycle that an up event is detected → `Digits`=1234 and the event is dropped.
- Load 16'hFA5C → `Digits`=16'h9959 with no pulse.
- Press `Up` and assert `Reset` one cycle later → `Digits`=`InitValue` and no increment after release. Then hold `Up` through reset release → exactly one increment, at the 3rd edge after release.
